// File: rtl/mips_pkg.sv
// mips_pkg: instruction format codes, field widths, load FSM states and word packing
package mips_pkg;
  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;
  localparam int OP_W = 6;
  localparam int REG_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMMI_W = 16;
  localparam int IMMJ_W = 26;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [1:0] fmt,
    input logic [OP_W-1:0] op,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] shamt,
    input logic [FUNCT_W-1:0] funct,
    input logic [IMMI_W-1:0] immi,
    input logic [IMMJ_W-1:0] immj
  );
    return fmt == FMT_R ? {6'b0, rs, rt, rd, shamt, funct} :
           fmt == FMT_I ? {op, rs, rt, immi} : {op, immj};
  endfunction
endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: two-entry FIFO with occupancy count; push/pop guarded against full/empty
module instr_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign do_push = push && count != 2'd2;
  assign do_pop = pop && count != 2'd0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I/J field requests into 32-bit words and streams them to consecutive memory addresses
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [1:0]          fmt,
  input  logic [OP_W-1:0]     op,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMMI_W-1:0]   immi,
  input  logic [IMMJ_W-1:0]   immj,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_ctr;
  logic [1:0] count;
  logic acc, legal, push, start_ok;
  assign start_ok = start && state == IDLE;
  assign acc = in_valid && in_ready;
  assign legal = fmt != FMT_BAD;
  assign push = acc && legal;
  assign out_valid = count != 2'd0;
  instr_fifo2 #(.W(ADDR_W + WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (out_valid && out_ready),
    .wdata ({addr_ctr, pack_word(fmt, op, rs, rt, rd, shamt, funct, immi, immj)}),
    .rdata ({mem_addr, mem_wdata}),
    .count (count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (acc && in_last ? DRAIN : RUN) :
                               (count == 2'd0 ? IDLE : DRAIN);
  always_comb begin
    in_ready = state == RUN && count < 2'd2;
    busy = state != IDLE;
    done = state == DRAIN && count == 2'd0;
  end
  // illegal requests neither consume an address nor clear the flag until the next load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_ctr <= '0;
      err <= 1'b0;
    end else if (start_ok) begin
      addr_ctr <= base_addr;
      err <= 1'b0;
    end else begin
      if (push) addr_ctr <= addr_ctr + 1'b1;
      if (acc && !legal) err <= 1'b1;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven single-word loads plus directed multi-cycle sequences
module tb_instr_encoder;
  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immi;
    logic [25:0] immj;
    logic [9:0]  base;
    logic [31:0] exp_w;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, in_last, out_valid, out_ready, busy, done, err;
  logic [9:0] base_addr, mem_addr;
  logic [1:0] fmt;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] immi;
  logic [25:0] immj;
  logic [31:0] mem_wdata;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [6];
  vec_t r1, r2, iw, jw, bad;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immi(immi), .immj(immj), .out_valid(out_valid), .out_ready(out_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic last);
    fmt = v.fmt; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.shamt; funct = v.funct; immi = v.immi; immj = v.immj;
    in_last = last;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input logic last);
    int t = 0;
    drive(v, last);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, 6'h3f, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 10'h010, 32'h00221820};
    vecs[1] = '{2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'h0, 26'h0, 10'h100, 32'h03ffffff};
    vecs[2] = '{2'd0, 6'h00, 5'd0, 5'd4, 5'd2, 5'd5, 6'h00, 16'h0, 26'h0, 10'h200, 32'h00041140};
    vecs[3] = '{2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hfffc, 26'h0, 10'h005, 32'h8fa8fffc};
    vecs[4] = '{2'd2, 6'h03, 5'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h3ffffff, 10'h3fe, 32'h0fffffff};
    vecs[5] = '{2'd1, 6'h0f, 5'd0, 5'd1, 5'd7, 5'd9, 6'h2a, 16'h1234, 26'h0, 10'h07f, 32'h3c011234};
    r1  = '{2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 10'h0, 32'h00221820};
    r2  = '{2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0, 26'h0, 10'h0, 32'h00853022};
    iw  = '{2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h5, 26'h0, 10'h0, 32'h20080005};
    jw  = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h100, 10'h0, 32'h08000100};
    bad = '{2'd3, 6'h11, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1, 26'h1, 10'h0, 32'h0};
    rst_n = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; fmt = '0; op = '0; rs = '0; rt = '0; rd = '0;
    shamt = '0; funct = '0; immi = '0; immj = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].base);
      chk($sformatf("v%0d_busy", i), 64'(busy), 1);
      send(vecs[i], 1'b1);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 1);
      chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vecs[i].base));
      chk($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_w));
      @(negedge clk);
      chk($sformatf("v%0d_done", i), 64'({done, err}), 64'b10);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), 64'({busy, done}), 0);
    end
    // I then J, back to back with a same-cycle push and pop
    do_start(10'h030);
    send(iw, 1'b0);
    chk("ij_addr0", 64'(mem_addr), 64'h030);
    chk("ij_wdata0", 64'(mem_wdata), 64'h20080005);
    send(jw, 1'b1);
    chk("ij_addr1", 64'(mem_addr), 64'h031);
    chk("ij_wdata1", 64'(mem_wdata), 64'h08000100);
    chk("ij_no_done_yet", 64'(done), 0);
    @(negedge clk);
    chk("ij_done", 64'(done), 1);
    @(negedge clk);
    chk("ij_done_pulse", 64'(done), 0);
    // backpressure: FIFO fills, third request stalls
    out_ready = 1'b0;
    do_start(10'h040);
    send(iw, 1'b0);
    send(jw, 1'b0);
    drive(r1, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_head", 64'({out_valid, mem_addr, mem_wdata}), {1'b1, 10'h040, 32'h20080005});
    @(negedge clk);
    chk("bp_stable", 64'({out_valid, mem_addr, mem_wdata}), {1'b1, 10'h040, 32'h20080005});
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", 64'({out_valid, mem_addr, mem_wdata}), {1'b1, 10'h041, 32'h08000100});
    chk("bp_ready_again", 64'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("bp_third", 64'({out_valid, mem_addr, mem_wdata}), {1'b1, 10'h042, 32'h00221820});
    @(negedge clk);
    chk("bp_done", 64'({done, out_valid}), 64'b10);
    @(negedge clk);
    // illegal format between two R words
    do_start(10'h020);
    send(r1, 1'b0);
    chk("bad_addr0", 64'(mem_addr), 64'h020);
    send(bad, 1'b0);
    chk("bad_err", 64'({err, out_valid}), 64'b10);
    send(r2, 1'b1);
    chk("bad_addr1", 64'({mem_addr, mem_wdata}), {10'h021, 32'h00853022});
    @(negedge clk);
    chk("bad_done_err", 64'({done, err}), 64'b11);
    @(negedge clk);
    chk("bad_err_sticky", 64'(err), 1);
    // address wrap, with a start pulse during RUN that must be ignored
    do_start(10'h3ff);
    chk("wrap_err_cleared", 64'(err), 0);
    send(r1, 1'b0);
    chk("wrap_addr0", 64'(mem_addr), 64'h3ff);
    do_start(10'h111);
    send(r2, 1'b1);
    chk("wrap_addr1", 64'({mem_addr, mem_wdata}), {10'h000, 32'h00853022});
    @(negedge clk);
    chk("wrap_done", 64'(done), 1);
    @(negedge clk);
    // reset with FIFO full mid-load
    out_ready = 1'b0;
    do_start(10'h050);
    send(bad, 1'b0);
    send(iw, 1'b0);
    send(jw, 1'b0);
    chk("mid_full", 64'({in_ready, out_valid, err, busy}), 64'b0111);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_ready", 64'({out_valid, in_ready}), 0);
    chk("mid_rst_bus", 64'({mem_addr, mem_wdata}), 0);
    chk("mid_rst_flags", 64'({busy, done, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", i), 64'({out_valid, busy}), 0);
    end
    do_start(10'h060);
    send(r1, 1'b1);
    chk("post_rst_new_load", 64'({out_valid, mem_addr, mem_wdata}), {1'b1, 10'h060, 32'h00221820});
    @(negedge clk);
    chk("post_rst_done", 64'(done), 1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  pulse; loads base_addr, begins a program load.
REQ-005 SHALL have port base_addr  input  ADDR_W  first word address of the load.
REQ-006 SHALL have port in_valid, in_ready  input/output  1  field-request handshake.
REQ-007 SHALL have port in_last  input  1  marks final request of the load.
REQ-008 SHALL have port fmt  input  2  0=R, 1=I, 2=J, 3=illegal.
REQ-009 SHALL have ports op[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0], immi[15:0], immj[25:0]  input  instruction fields.
REQ-010 SHALL have ports out_valid, out_ready  output/input  1  memory-write handshake.
REQ-011 SHALL have ports mem_addr[ADDR_W-1:0], mem_wdata[31:0]  output  write address and packed word.
REQ-012 SHALL have ports busy, done, err  output  1  load active; one-cycle completion pulse; sticky illegal-format flag.

Function
REQ-013 SHALL pack R as {6'b0, rs, rt, rd, shamt, funct}; op ignored.
REQ-014 SHALL pack I as {op, rs, rt, immi}; J as {op, immj}.
REQ-015 SHALL implement FSM IDLE -> RUN (start) -> DRAIN (accepted in_last) -> IDLE (FIFO empty, done=1 for that one cycle).
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL drive in_ready = (state==RUN) && (fifo_count<2).
REQ-018 SHALL, on accepted legal request, push {addr_ctr, packed word} into 2-entry FIFO and increment addr_ctr, modulo 2^ADDR_W (1023 wraps to 0).
REQ-019 SHALL, on accepted fmt=3, push nothing, leave addr_ctr unchanged, set err.
REQ-020 SHALL honour in_last even when its request is illegal.
REQ-021 SHALL present FIFO head on out_valid/mem_addr/mem_wdata; head popped when out_valid && out_ready.
REQ-022 SHALL give latency 1: word accepted in cycle N is visible on out_valid in N+1 if FIFO was empty.
REQ-023 SHALL allow push and pop in the same cycle at count 1 (count stays 1); at count 2 only pop.
REQ-024 SHALL hold mem_addr/mem_wdata stable while out_valid && !out_ready.
REQ-025 SHALL assert busy in RUN and DRAIN.
REQ-026 SHALL clear err only on reset or on start accepted in IDLE.

Reset
REQ-027 SHALL, on rst_n low, force IDLE, empty FIFO, addr_ctr=0, in_ready=0, out_valid=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, immediately.
REQ-028 SHALL discard in-flight FIFO contents and drop any pending load on reset mid-operation; no write after reset until a new start.

Structure
REQ-029 SHALL place fmt encodings (FMT_R/FMT_I/FMT_J/FMT_BAD), field widths and the FSM state typedef in shared package mips_pkg.
REQ-030 SHALL implement the FIFO as sub-module instr_fifo2 (depth 2, width ADDR_W+32, count output).

Verification
REQ-031 SHALL test: start base 0x010; R rs=1 rt=2 rd=3 funct=0x20, out_ready=1 -> mem_addr 0x010, mem_wdata 0x00221820, next cycle.
REQ-032 SHALL test: I op=0x08 rs=0 rt=8 immi=5 then J op=0x02 immj=0x100 (last) -> 0x20080005 @base, 0x08000100 @base+1, done one cycle after final pop.
REQ-033 SHALL test: out_ready=0, three valid requests -> in_ready low after two, outputs stable; release -> in order, none lost.
REQ-034 SHALL test: fmt=3 between two R words -> err=1, addresses consecutive (no gap), err survives to done.
REQ-035 SHALL test: base 0x3FF, two words -> addresses 0x3FF then 0x000.
REQ-036 SHALL test: rst_n low with FIFO full mid-load -> all outputs reset same cycle, no out_valid until new start.
